// File: rtl/simple2_pkg.sv
// simple2_pkg: shared FSM encoding, LFSR taps and default seed for the simple2 test driver.
package simple2_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FLUSH = 3'd1;
  localparam state_t S_RUN   = 3'd2;
  localparam state_t S_TAIL  = 3'd3;
  localparam state_t S_DONE  = 3'd4;
  // x^16+x^14+x^13+x^11 seen from a right-shifting register: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/simple2_lfsr16.sv
// simple2_lfsr16: 16-bit Fibonacci LFSR shifting toward bit 0, with seed load and advance.
module simple2_lfsr16 import simple2_pkg::*; #(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load_i ? SEED : adv_i ? {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]} : lfsr_q;
  always_ff @(posedge clk) lfsr_q <= lfsr_d;
  assign state_o = lfsr_q;
endmodule

// File: rtl/simple2_test_driver.sv
// simple2_test_driver: drives LFSR vectors into a one-flop DUT and checks it against an inline model.
module simple2_test_driver import simple2_pkg::*; #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          ERR_W       = 16
) (
  input  logic             tau2015_clk,
  input  logic             rst,
  input  logic             start,
  output logic             inp1,
  output logic             inp2,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      vec_count
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? DEFAULT_SEED : LFSR_SEED;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
  state_t           state_q, state_d;
  logic [1:0]       inp_q, inp_d;
  logic             busy_q, done_q, pass_q, model_q, model_d, go, miss;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      vec_q, vec_d, lfsr;
  simple2_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (tau2015_clk),
    .load_i (rst || go),
    .adv_i  (state_q == S_RUN),
    .state_o(lfsr)
  );
  // inp_q holds what the DUT sees this cycle; the next RUN vector is lfsr_next[1:0] == lfsr[2:1]
  always_comb begin
    go      = start && (state_q == S_IDLE || state_q == S_DONE);
    miss    = (state_q == S_RUN || state_q == S_TAIL) && (dut_out == model_q);
    state_d = go ? S_FLUSH :
              state_q == S_FLUSH ? S_RUN :
              state_q == S_RUN ? (vec_q == LAST ? S_TAIL : S_RUN) :
              state_q == S_TAIL ? S_DONE : state_q;
    model_d = state_q == S_RUN ? (inp_q[0] & inp_q[1] & ~model_q) :
              state_q == S_FLUSH ? 1'b0 : model_q;
    err_d   = go ? '0 : (miss && err_q != '1) ? err_q + 1'b1 : err_q;
    vec_d   = go ? '0 : state_q == S_RUN ? vec_q + 16'd1 : vec_q;
    inp_d   = state_d != S_RUN ? 2'b00 : state_q == S_FLUSH ? lfsr[1:0] : lfsr[2:1];
  end
  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      inp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      model_q <= 1'b0;
      err_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      inp_q   <= inp_d;
      busy_q  <= state_d inside {S_FLUSH, S_RUN, S_TAIL};
      done_q  <= state_d == S_DONE;
      pass_q  <= state_d == S_DONE && err_d == '0;
      model_q <= model_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
    end
  end
  assign inp1      = inp_q[0];
  assign inp2      = inp_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;
endmodule

// File: tb/tb_simple2_test_driver.sv
// tb_simple2_test_driver: scoreboard bench with behavioural one-flop DUTs around two driver instances.
module tb_simple2_test_driver;
  typedef struct {int err; int pass; int vec; int cyc;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  exp_t qa[$], qb[$];
  logic a_rst, a_start, a_inp1, a_inp2, a_out, a_busy, a_done, a_pass, a_inv, a_pre, a_q;
  logic [15:0] a_err, a_vec;
  logic b_rst, b_start, b_inp1, b_inp2, b_out, b_busy, b_done, b_pass, b_q;
  logic [3:0] b_err;
  logic [15:0] b_vec;
  logic [1:0] seq1 [258];
  // behavioural DUT: q <= inp1 & inp2 & ~q, out = ~q (inverted variant drives q)
  always_ff @(posedge clk) a_q <= a_pre ? 1'b1 : (a_inp1 & a_inp2 & ~a_q);
  always_ff @(posedge clk) b_q <= b_inp1 & b_inp2 & ~b_q;
  assign a_out = a_inv ? a_q : ~a_q;
  assign b_out = b_q;
  simple2_test_driver #(.NUM_VECTORS(256), .LFSR_SEED(16'hACE1), .ERR_W(16)) dut_a (
    .tau2015_clk(clk), .rst(a_rst), .start(a_start), .inp1(a_inp1), .inp2(a_inp2),
    .dut_out(a_out), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .vec_count(a_vec));
  simple2_test_driver #(.NUM_VECTORS(100), .LFSR_SEED(16'h0000), .ERR_W(4)) dut_b (
    .tau2015_clk(clk), .rst(b_rst), .start(b_start), .inp1(b_inp1), .inp2(b_inp2),
    .dut_out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .vec_count(b_vec));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_run(input int inst, input int err, input int pass, input int vec, input int cyc);
    exp_t e;
    e.err = err; e.pass = pass; e.vec = vec; e.cyc = cyc;
    if (inst == 0) qa.push_back(e); else qb.push_back(e);
  endtask
  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask
  task automatic wait_a_done();
    for (int i = 0; i < 600 && !a_done; i++) @(negedge clk);
    chk("a_done_seen", a_done, 1);
  endtask
  task automatic wait_a_vec(input int n);
    for (int i = 0; i < 600 && a_vec != 16'(n); i++) @(negedge clk);
    chk("a_vec_reached", a_vec, n);
  endtask
  task automatic chk_a_idle(input string tag);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_pass"}, a_pass, 0);
    chk({tag, "_err"}, a_err, 0);
    chk({tag, "_vec"}, a_vec, 0);
    chk({tag, "_inp"}, {a_inp1, a_inp2}, 0);
  endtask
  int cyc_a = 0, cyc_b = 0;
  logic a_done_p = 1'b0, b_done_p = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (a_done && !a_done_p) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done with empty scoreboard");
      end else begin
        e = qa.pop_front();
        chk("a_err_count", a_err, e.err);
        chk("a_pass", a_pass, e.pass);
        chk("a_vec_count", a_vec, e.vec);
        chk("a_busy_cycles", cyc_a, e.cyc);
      end
      cyc_a = 0;
    end else if (a_busy) cyc_a++;
    else if (!a_done) cyc_a = 0;
    a_done_p = a_done;
  end
  always @(negedge clk) begin
    exp_t e;
    if (b_done && !b_done_p) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done with empty scoreboard");
      end else begin
        e = qb.pop_front();
        chk("b_err_count", b_err, e.err);
        chk("b_pass", b_pass, e.pass);
        chk("b_vec_count", b_vec, e.vec);
        chk("b_busy_cycles", cyc_b, e.cyc);
      end
      cyc_b = 0;
    end else if (b_busy) cyc_b++;
    else if (!b_done) cyc_b = 0;
    b_done_p = b_done;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] l;
    logic [31:0] act, exp;
    int nmis;
    a_rst = 1; b_rst = 1; a_start = 0; b_start = 0; a_inv = 0; a_pre = 0;
    repeat (3) @(negedge clk);
    a_rst = 0; b_rst = 0;
    chk_a_idle("a_reset");
    chk("b_reset_err", b_err, 0);
    // correct DUT, full run; record the vector sequence
    expect_run(0, 0, 1, 256, 258);
    pulse_a_start();
    for (int i = 0; i < 258; i++) begin
      seq1[i] = {a_inp1, a_inp2};
      @(negedge clk);
    end
    l = 16'hACE1; act = '0; exp = '0;
    for (int k = 0; k < 16; k++) begin
      exp[2*k +: 2] = {l[0], l[1]};
      act[2*k +: 2] = seq1[k+1];
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    chk("a_first16_vectors", act, exp);
    chk("a_flush_tail_zero", {seq1[0], seq1[257]}, 0);
    wait_a_done();
    // inverted DUT: every one of 257 compares mismatches
    a_inv = 1;
    expect_run(0, 257, 0, 256, 258);
    pulse_a_start();
    wait_a_done();
    // restart from DONE clears counters; a start during RUN is ignored
    a_inv = 0;
    expect_run(0, 0, 1, 256, 258);
    pulse_a_start();
    chk("a_restart_busy", a_busy, 1);
    chk("a_restart_done", a_done, 0);
    chk("a_restart_err", a_err, 0);
    chk("a_restart_vec", a_vec, 0);
    wait_a_vec(10);
    pulse_a_start();
    wait_a_done();
    // DUT flop preset to 1 up to the flush
    a_pre = 1;
    expect_run(0, 0, 1, 256, 258);
    pulse_a_start();
    a_pre = 0;
    wait_a_done();
    // reset mid-run, then rerun must replay the same vectors
    pulse_a_start();
    wait_a_vec(50);
    a_rst = 1;
    @(negedge clk);
    a_rst = 0;
    chk_a_idle("a_midrun_rst");
    @(negedge clk);
    chk("a_stays_idle", a_busy, 0);
    expect_run(0, 0, 1, 256, 258);
    pulse_a_start();
    nmis = 0;
    for (int i = 0; i < 258; i++) begin
      if ({a_inp1, a_inp2} != seq1[i]) nmis++;
      @(negedge clk);
    end
    chk("a_seq_replay_mismatches", nmis, 0);
    wait_a_done();
    // inverted DUT on a 4-bit counter saturates at 15; zero seed falls back to default
    expect_run(1, 15, 0, 100, 102);
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    chk("b_first_vector", {b_inp1, b_inp2}, 0);
    @(negedge clk);
    chk("b_seed_vector", {b_inp1, b_inp2}, 2'b10);
    for (int i = 0; i < 300 && !b_done; i++) @(negedge clk);
    chk("b_done_seen", b_done, 1);
    repeat (2) @(negedge clk);
    chk("a_scoreboard_drained", qa.size(), 0);
    chk("b_scoreboard_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple2_test_driver.md
SIMPLE2_TEST_DRIVER -- requirements
Module: simple2_test_driver

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 256: number of random input vectors applied per run (1..65535).
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR load value; 0 SHALL be replaced by 16'hACE1.
REQ-003 SHALL have parameter ERR_W, default 16: width of err_count.
REQ-004 SHALL have port tau2015_clk  input  1  sole clock, all flops rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a run in IDLE or DONE.
REQ-007 SHALL have port inp1  output  1  drive to DUT inp1.
REQ-008 SHALL have port inp2  output  1  drive to DUT real_inp2.
REQ-009 SHALL have port dut_out  input  1  DUT out, sampled each compare cycle.
REQ-010 SHALL have port busy  output  1  high in FLUSH, RUN, TAIL.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port pass  output  1  valid when done; 1 iff err_count==0.
REQ-013 SHALL have port err_count  output  ERR_W  mismatch count, saturating.
REQ-014 SHALL have port vec_count  output  16  vectors applied this run.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, RUN, TAIL, DONE.
REQ-016 IDLE/DONE + start -> FLUSH; clears err_count and vec_count, loads LFSR with seed.
REQ-017 FLUSH SHALL last exactly 1 cycle, drive inp1=inp2=0 (forces DUT flop to 0 regardless of X), set model_q<=0, then go to RUN.
REQ-018 In each RUN cycle, the block SHALL drive inp1=lfsr[0] and inp2=lfsr[1].
REQ-019 In each RUN cycle, the block SHALL compare dut_out against ~model_q and increment err_count on mismatch.
REQ-020 In each RUN cycle, the block SHALL update model_q<=(inp1&inp2)&~model_q at the edge.
REQ-021 In each RUN cycle, the block SHALL advance the LFSR once and increment vec_count.
REQ-022 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11 that shifts toward bit 0 and is never all-zero.
REQ-023 RUN SHALL exit to TAIL after the cycle in which vec_count reaches NUM_VECTORS.
REQ-024 TAIL SHALL last 1 cycle, drive 0s, perform a final compare, then go to DONE; total compares per run = NUM_VECTORS+1.
REQ-025 DONE SHALL hold done=1 and hold pass/err_count/vec_count stable until start or rst.
REQ-026 start while busy SHALL be ignored.
REQ-027 err_count SHALL saturate at all-ones; no wrap.
REQ-028 A mismatch in the same cycle as saturation SHALL leave err_count at max.
REQ-029 Outside FLUSH/RUN/TAIL, inp1=inp2=0.
REQ-030 No compare SHALL occur in IDLE, FLUSH, or DONE.
REQ-031 Outputs inp1, inp2, busy, done, and pass SHALL be registered (no combinational path from dut_out to any output).

Reset
REQ-032 rst SHALL force IDLE; busy=0, done=0, pass=0, err_count=0, vec_count=0, inp1=inp2=0, model_q=0, LFSR=seed; effective on the next edge from any state, including mid-RUN.
REQ-033 Immediately after rst, the block SHALL require a new start; the aborted run leaves no residue.

Structure
REQ-034 The shared package simple2_pkg SHALL hold the FSM state enum, the LFSR tap mask, and the default seed constant.
REQ-035 A single sub-module simple2_lfsr16 (load, advance, 16-bit state) SHALL be instantiated.
REQ-036 The golden model SHALL be inline: one flop plus the next-state equation, with no DUT netlist copy.

Verification
REQ-037 Bench SHALL run scenario: correct behavioral DUT, NUM_VECTORS=256, one start -> done after 258 cycles, err_count=0, pass=1, vec_count=256.
REQ-038 Bench SHALL run scenario: DUT with inverted output (dut_out=n3), NUM_VECTORS=256 -> err_count=257, pass=0.
REQ-039 Bench SHALL run scenario: DUT flop X/1 before FLUSH, correct DUT -> err_count=0 (flush removes initial state).
REQ-040 Bench SHALL run scenario: inverted DUT, ERR_W=4, NUM_VECTORS=100 -> err_count=15 (saturated), pass=0.
REQ-041 Bench SHALL run scenario: rst asserted at vec_count=50 -> next cycle IDLE, all outputs 0; new start yields identical inp1/inp2 sequence as first run.
REQ-042 Bench SHALL run scenario: start pulsed during RUN and again in DONE -> first ignored, second restarts with err_count=0, vec_count=0, FLUSH next cycle.
